// File: rtl/cordic_iter_ctrl.sv
// Iterative rotation-mode CORDIC sequencer: one shared shift-add stage, one micro-rotation per
// clock, with valid/ready handshakes on the angle input and the cos/sin result.
module cordic_iter_ctrl #(
   parameter int unsigned N  = 10,
   parameter int unsigned ZW = 11,
   parameter int unsigned XW = 17
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [ZW-1:0] in_z,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [XW-1:0] out_x,
   output logic [XW-1:0] out_y,
   output logic [ZW:0]   out_z,
   output logic          busy
);

   localparam int unsigned IW = XW + 2;
   localparam int unsigned CW = 4;

   localparam logic signed [IW-1:0] XInit = IW'(39797);
   localparam logic [ZW-1:0]        ZMax  = ZW'(1440);
   localparam logic [CW-1:0]        ILast = CW'(N - 1);
   localparam logic signed [IW-1:0] SatHi = IW'((1 << (XW - 1)) - 1);
   localparam logic signed [IW-1:0] SatLo = ~SatHi;

   typedef enum logic [1:0] {
      StIdle,
      StRot,
      StDone
   } state_e;

   state_e               state;
   logic [CW-1:0]        iter;
   logic signed [IW-1:0] x;
   logic signed [IW-1:0] y;
   logic signed [ZW:0]   z;

   logic signed [IW-1:0] x_sh;
   logic signed [IW-1:0] y_sh;
   logic signed [IW-1:0] x_nxt;
   logic signed [IW-1:0] y_nxt;
   logic signed [ZW:0]   z_nxt;
   logic signed [ZW:0]   atan;
   logic signed [ZW:0]   z_load;

   // arctan(2^-i) in degrees x 16, rounded
   function automatic logic signed [ZW:0] atan_rom(input logic [CW-1:0] idx);
      logic signed [ZW:0] v;
      case (idx)
         4'd0:    v = (ZW+1)'(720);
         4'd1:    v = (ZW+1)'(425);
         4'd2:    v = (ZW+1)'(225);
         4'd3:    v = (ZW+1)'(114);
         4'd4:    v = (ZW+1)'(57);
         4'd5:    v = (ZW+1)'(29);
         4'd6:    v = (ZW+1)'(14);
         4'd7:    v = (ZW+1)'(7);
         4'd8:    v = (ZW+1)'(4);
         4'd9:    v = (ZW+1)'(2);
         default: v = '0;
      endcase
      return v;
   endfunction

   function automatic logic [XW-1:0] sat(input logic signed [IW-1:0] v);
      logic signed [IW-1:0] c;
      if (v > SatHi) begin
         c = SatHi;
      end else if (v < SatLo) begin
         c = SatLo;
      end else begin
         c = v;
      end
      return c[XW-1:0];
   endfunction

   // Angles above 90 degrees are clamped; the clamped value is always positive in z.
   always_comb begin
      z_load = '0;
      if (in_z > ZMax) begin
         z_load = $signed({1'b0, ZMax});
      end else begin
         z_load = $signed({1'b0, in_z});
      end
   end

   // Both x and y update from the pre-edge values of the other.
   always_comb begin
      x_sh  = x >>> iter;
      y_sh  = y >>> iter;
      atan  = atan_rom(iter);
      x_nxt = x;
      y_nxt = y;
      z_nxt = z;
      if (!z[ZW]) begin
         x_nxt = x - y_sh;
         y_nxt = y + x_sh;
         z_nxt = z - atan;
      end else begin
         x_nxt = x + y_sh;
         y_nxt = y - x_sh;
         z_nxt = z + atan;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= StIdle;
         iter      <= '0;
         x         <= '0;
         y         <= '0;
         z         <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         out_x     <= '0;
         out_y     <= '0;
         out_z     <= '0;
      end else begin
         case (state)
            StIdle: begin
               if (in_valid) begin
                  x        <= XInit;
                  y        <= '0;
                  z        <= z_load;
                  iter     <= '0;
                  state    <= StRot;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            StRot: begin
               x    <= x_nxt;
               y    <= y_nxt;
               z    <= z_nxt;
               iter <= iter + CW'(1);
               if (iter == ILast) begin
                  state     <= StDone;
                  out_valid <= 1'b1;
                  out_x     <= sat(x_nxt);
                  out_y     <= sat(y_nxt);
                  out_z     <= z_nxt;
               end
            end
            StDone: begin
               // in_valid is deliberately not looked at here: no back-to-back accepts
               if (out_ready) begin
                  state     <= StIdle;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= StIdle;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Directed bench for cordic_iter_ctrl: handshake timing, stall, clamp, reset and an angle sweep
// against a small integer model of the iteration.
module tb_cordic_iter_ctrl;

   localparam int N  = 10;
   localparam int ZW = 11;
   localparam int XW = 17;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [ZW-1:0] in_z = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [XW-1:0] out_x;
   logic [XW-1:0] out_y;
   logic [ZW:0]   out_z;
   logic          busy;

   int total = 0;
   int bad = 0;
   int atan_tab[10] = '{720, 425, 225, 114, 57, 29, 14, 7, 4, 2};

   cordic_iter_ctrl #(.N(N), .ZW(ZW), .XW(XW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_z      (in_z),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_x     (out_x),
      .out_y     (out_y),
      .out_z     (out_z),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int sx();
      return int'($signed(out_x));
   endfunction
   function automatic int sy();
      return int'($signed(out_y));
   endfunction
   function automatic int sz();
      return int'($signed(out_z));
   endfunction

   function automatic void model(input int zin, output int mx, output int my, output int mz);
      int x, y, z, xs, ys;
      x = 39797;
      y = 0;
      z = (zin > 1440) ? 1440 : zin;
      for (int i = 0; i < N; i++) begin
         xs = x >>> i;
         ys = y >>> i;
         if (z >= 0) begin
            x = x - ys;
            y = y + xs;
            z = z - atan_tab[i];
         end else begin
            x = x + ys;
            y = y - xs;
            z = z + atan_tab[i];
         end
      end
      if (x > 65535) x = 65535;
      if (x < -65536) x = -65536;
      if (y > 65535) y = 65535;
      if (y < -65536) y = -65536;
      mx = x;
      my = y;
      mz = z;
   endfunction

   // Issues one request and waits for out_valid; lat stays -1 if nothing was accepted or returned.
   task automatic run_req(input int zv, output int lat, output int ox, output int oy,
                          output int oz);
      lat = -1;
      ox = 0;
      oy = 0;
      oz = 0;
      for (int w = 0; w < 20 && !in_ready; w++) tick();
      if (in_ready) begin
         in_valid = 1'b1;
         in_z = zv[ZW-1:0];
         tick();
         in_valid = 1'b0;
         for (int c = 1; c <= 40; c++) begin
            tick();
            if (out_valid) begin
               lat = c;
               ox = sx();
               oy = sy();
               oz = sz();
               break;
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      repeat (3) tick();
      total++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         bad++;
         $display("FAIL reset_ctrl: got rdy/vld/busy=%b want 100", {in_ready, out_valid, busy});
      end
      total++;
      if (out_x !== '0 || out_y !== '0 || out_z !== '0) begin
         bad++;
         $display("FAIL reset_data: got x=%0d y=%0d z=%0d want 0 0 0", sx(), sy(), sz());
      end
      rst_n = 1'b1;
      tick();
      total++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         bad++;
         $display("FAIL post_reset: got rdy/vld/busy=%b want 100", {in_ready, out_valid, busy});
      end
   endtask

   task automatic test_45();
      int lat, ox, oy, oz, mx, my, mz;
      out_ready = 1'b1;
      run_req(720, lat, ox, oy, oz);
      model(720, mx, my, mz);
      total++;
      if (lat !== N) begin
         bad++;
         $display("FAIL 45_latency: got %0d want %0d", lat, N);
      end
      total++;
      if (!(ox >= 46341 - 160 && ox <= 46341 + 160 && oy >= 46341 - 160 && oy <= 46341 + 160))
      begin
         bad++;
         $display("FAIL 45_xy: got x=%0d y=%0d want 46341+-160", ox, oy);
      end
      total++;
      if (!(oz >= -2 && oz <= 2)) begin
         bad++;
         $display("FAIL 45_z: got %0d want |z|<=2", oz);
      end
      total++;
      if (ox !== mx || oy !== my || oz !== mz) begin
         bad++;
         $display("FAIL 45_exact: got %0d %0d %0d want %0d %0d %0d", ox, oy, oz, mx, my, mz);
      end
      tick();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL 45_one_valid: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_back_to_back();
      int acc_cyc[2];
      int rx[2], ry[2];
      int nacc, nres, cyc, mx, my, mz;
      bit acc;
      nacc = 0;
      nres = 0;
      cyc = 0;
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_z = '0;
      for (int k = 0; k < 60 && nres < 2; k++) begin
         acc = in_ready && in_valid;
         tick();
         cyc++;
         if (acc && nacc < 2) begin
            acc_cyc[nacc] = cyc;
            nacc++;
            if (nacc == 1) in_z = 11'd1440;
            else in_valid = 1'b0;
         end
         if (out_valid) begin
            rx[nres] = sx();
            ry[nres] = sy();
            nres++;
         end
      end
      in_valid = 1'b0;
      total++;
      if (nres !== 2 || nacc !== 2) begin
         bad++;
         $display("FAIL b2b_count: got acc=%0d res=%0d want 2 2", nacc, nres);
      end else begin
         total++;
         if (acc_cyc[1] - acc_cyc[0] !== N + 2) begin
            bad++;
            $display("FAIL b2b_spacing: got %0d want %0d", acc_cyc[1] - acc_cyc[0], N + 2);
         end
         total++;
         if (!(rx[0] >= 65535 - 160 && rx[0] <= 65535 && ry[0] >= -160 && ry[0] <= 160)) begin
            bad++;
            $display("FAIL b2b_0deg: got x=%0d y=%0d want 65375..65535, 0+-160", rx[0], ry[0]);
         end
         total++;
         if (!(rx[1] >= -160 && rx[1] <= 160 && ry[1] >= 65535 - 160 && ry[1] <= 65535)) begin
            bad++;
            $display("FAIL b2b_90deg: got x=%0d y=%0d want 0+-160, 65375..65535", rx[1], ry[1]);
         end
         model(1440, mx, my, mz);
         total++;
         if (rx[1] !== mx || ry[1] !== my) begin
            bad++;
            $display("FAIL b2b_90_exact: got %0d %0d want %0d %0d", rx[1], ry[1], mx, my);
         end
      end
      tick();
   endtask

   task automatic test_clamp_stall();
      int c, ox, oy, oz, mx, my, mz, stall_bad;
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_z = 11'd2000;
      tick();
      in_valid = 1'b0;
      c = 0;
      repeat (3) begin
         tick();
         c++;
      end
      total++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL rot_flags: got rdy=%b busy=%b want 0 1", in_ready, busy);
      end
      in_valid = 1'b1;
      in_z = 11'd720;
      tick();
      c++;
      in_valid = 1'b0;
      for (int k = 0; k < 40 && !out_valid; k++) begin
         tick();
         c++;
      end
      total++;
      if (c !== N || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL clamp_latency: got %0d vld=%b want %0d 1", c, out_valid, N);
      end
      ox = sx();
      oy = sy();
      oz = sz();
      model(1440, mx, my, mz);
      total++;
      if (ox !== mx || oy !== my || oz !== mz) begin
         bad++;
         $display("FAIL clamp_exact: got %0d %0d %0d want %0d %0d %0d", ox, oy, oz, mx, my, mz);
      end
      in_valid = 1'b1;
      stall_bad = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         total++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || sx() !== ox || sy() !== oy || sz() !== oz)
         begin
            bad++;
            $display("FAIL stall_cycle%0d: got vld=%b rdy=%b x=%0d y=%0d z=%0d want 1 0 %0d %0d %0d",
                     k, out_valid, in_ready, sx(), sy(), sz(), ox, oy, oz);
         end
      end
      // out_ready and in_valid together in DONE: only the output handshake completes
      out_ready = 1'b1;
      tick();
      total++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         bad++;
         $display("FAIL simul_hs: got rdy/vld/busy=%b want 100", {in_ready, out_valid, busy});
      end
      tick();
      in_valid = 1'b0;
      total++;
      if ({in_ready, busy} !== 2'b01) begin
         bad++;
         $display("FAIL next_accept: got rdy/busy=%b want 01", {in_ready, busy});
      end
      c = 0;
      for (int k = 0; k < 40 && !out_valid; k++) begin
         tick();
         c++;
      end
      model(720, mx, my, mz);
      total++;
      if (c !== N || sx() !== mx || sy() !== my || sz() !== mz) begin
         bad++;
         $display("FAIL after_stall: got lat=%0d %0d %0d %0d want %0d %0d %0d %0d",
                  c, sx(), sy(), sz(), N, mx, my, mz);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      int lat, ox, oy, oz, mx, my, mz;
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_z = 11'd480;
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      rst_n = 1'b0;
      tick();
      total++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         bad++;
         $display("FAIL mid_reset_ctrl: got rdy/vld/busy=%b want 100", {in_ready, out_valid, busy});
      end
      total++;
      if (out_x !== '0 || out_y !== '0 || out_z !== '0) begin
         bad++;
         $display("FAIL mid_reset_data: got %0d %0d %0d want 0 0 0", sx(), sy(), sz());
      end
      rst_n = 1'b1;
      tick();
      total++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset_idle: got busy=%b vld=%b want 0 0", busy, out_valid);
      end
      run_req(480, lat, ox, oy, oz);
      model(480, mx, my, mz);
      total++;
      if (lat !== N || !(ox >= 56756 - 160 && ox <= 56756 + 160 && oy >= 32768 - 160 &&
                         oy <= 32768 + 160)) begin
         bad++;
         $display("FAIL 30deg: got lat=%0d x=%0d y=%0d want %0d 56756+-160 32768+-160",
                  lat, ox, oy, N);
      end
      total++;
      if (ox !== mx || oy !== my || oz !== mz) begin
         bad++;
         $display("FAIL 30deg_exact: got %0d %0d %0d want %0d %0d %0d", ox, oy, oz, mx, my, mz);
      end
      tick();
   endtask

   task automatic test_sweep();
      int lat, ox, oy, oz, mx, my, mz;
      out_ready = 1'b1;
      for (int zv = 0; zv <= 1440; zv += 16) begin
         run_req(zv, lat, ox, oy, oz);
         model(zv, mx, my, mz);
         total++;
         if (lat !== N) begin
            bad++;
            $display("FAIL sweep_lat z=%0d: got %0d want %0d", zv, lat, N);
         end
         total++;
         if (ox !== mx || oy !== my || oz !== mz) begin
            bad++;
            $display("FAIL sweep z=%0d: got %0d %0d %0d want %0d %0d %0d",
                     zv, ox, oy, oz, mx, my, mz);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_45();
      test_back_to_back();
      test_clamp_stall();
      test_reset_mid();
      test_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
